// File: rtl/systolic_result_drain.sv
// Drain for PE results: show-ahead FIFO with column/end-of-row tags
// and a running completed-row count.
module systolic_result_drain #(
  parameter  int acc_width = 32,
  parameter  int DEPTH     = 4,
  parameter  int ROW_LEN   = 4,
  localparam int IW        = $clog2(ROW_LEN),
  localparam int PW        = $clog2(DEPTH),
  localparam int LW        = PW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pe_stb,
  input  logic [acc_width-1:0] pe_acc,
  output logic                 pe_busy,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [acc_width-1:0] m_acc,
  output logic [IW-1:0]        m_index,
  output logic                 m_last,
  output logic [LW-1:0]        level,
  output logic [15:0]          rows_done
);

  logic [acc_width-1:0] acc_mem [DEPTH];
  logic [IW-1:0]        idx_mem [DEPTH];
  logic [DEPTH-1:0]     last_mem;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [IW-1:0] col_q, col_d;
  logic [15:0]   rows_q, rows_d;

  logic push;
  logic pop;
  logic col_end;

  // Busy depends only on reset and registered occupancy.
  assign pe_busy   = reset | (level_q == LW'(DEPTH));
  assign m_valid   = (level_q != '0);
  assign push      = pe_stb & ~pe_busy;
  assign pop       = m_valid & m_ready;
  assign col_end   = (col_q == IW'(ROW_LEN - 1));

  assign m_acc     = acc_mem[rptr_q];
  assign m_index   = idx_mem[rptr_q];
  assign m_last    = last_mem[rptr_q];
  assign level     = level_q;
  assign rows_done = rows_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    col_d   = col_q;
    rows_d  = rows_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
      col_d  = col_end ? '0 : col_q + 1'b1;
      if (col_end)
        rows_d = rows_q + 1'b1;
    end
    if (pop)
      rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      col_q   <= '0;
      rows_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
    end
  end

  // Storage is never cleared; reset only discards entries via pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      acc_mem[wptr_q]  <= pe_acc;
      idx_mem[wptr_q]  <= col_q;
      last_mem[wptr_q] <= col_end;
    end
  end

endmodule
